seq_feeder: RTL and testbench

Upstream stage of the 64-PE affine-gap alignment array. Accepts one packed nucleotide stream per job: 64 query bases followed by 1–1023 reference bases. Buffers the reference in an internal RAM, then drives the array's start / query / reference-base inputs with the exact cycle alignment the array expects. Holds off the next job until the array has drained.

---
 rtl/seq_feeder_pkg.sv | 25 ++
 rtl/seq_feeder_if.sv | 22 ++
 rtl/seq_feeder_ref_ram.sv | 20 ++
 rtl/seq_feeder.sv | 158 +++++++++++++++
 tb/tb_seq_feeder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_feeder_pkg.sv
// Shared alignment package: base codes, array geometry, score type and feeder state encoding.
package seq_feeder_pkg;
   localparam int unsigned N_PE      = 64;
   localparam int unsigned MAX_REF   = 1023;
   localparam int unsigned DRAIN_CYC = N_PE + 1;
   localparam int unsigned REF_AW    = 10;

   localparam logic [1:0] BASE_A = 2'd0;
   localparam logic [1:0] BASE_C = 2'd1;
   localparam logic [1:0] BASE_G = 2'd2;
   localparam logic [1:0] BASE_T = 2'd3;

   typedef logic [13:0]       score_t;
   typedef logic [REF_AW-1:0] ref_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_Q,
      ST_LOAD_R,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH
   } feeder_state_e;
endpackage

// File: rtl/seq_feeder_if.sv
// Base-stream input and array-drive outputs of seq_feeder; names are from the feeder's point of view.
interface seq_feeder_if;
   import seq_feeder_pkg::*;

   logic              i_base_valid;
   logic              o_base_ready;
   logic [1:0]        i_base;
   logic              i_base_last;
   logic              o_start;
   logic [2*N_PE-1:0] o_B;
   logic [1:0]        o_A;

   modport master (
      input  i_base_valid, i_base, i_base_last,
      output o_base_ready, o_start, o_B, o_A
   );

   modport slave (
      output i_base_valid, i_base, i_base_last,
      input  o_base_ready, o_start, o_B, o_A
   );
endinterface

// File: rtl/seq_feeder_ref_ram.sv
// seq_ref_ram: single-port (MAX_REF+1) x 2 reference buffer with registered read; swap for a vendor macro.
module seq_ref_ram
   import seq_feeder_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_we,
   input  ref_addr_t  i_addr,
   input  logic [1:0] i_wdata,
   output logic [1:0] o_rdata
);
   logic [1:0] r_mem [MAX_REF+1];
   logic [1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/seq_feeder.sv
// Feeds query/reference bases to the 64-PE alignment array with start-aligned timing.
// Build option: SEQ_FEEDER_ERR_EN reports malformed jobs on o_err instead of padding/clamping them.
module seq_feeder
   import seq_feeder_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   seq_feeder_if.master bus,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_err
);
`ifdef SEQ_FEEDER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   feeder_state_e     r_state;
   logic [2*N_PE-1:0] r_q;
   logic [5:0]        r_qcnt;
   ref_addr_t         r_rcnt;
   ref_addr_t         r_len;
   logic [6:0]        r_dcnt;
   logic              r_start;
   logic              r_done;
   logic              r_err;

   logic              w_acc;
   logic              w_we;
   ref_addr_t         w_addr;
   logic [1:0]        w_wdata;
   logic [1:0]        w_rdata;

   assign bus.o_base_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD_Q) ||
                             (r_state == ST_LOAD_R) || (r_state == ST_FLUSH);
   assign w_acc    = bus.i_base_valid & bus.o_base_ready;
   assign bus.o_start = r_start;
   assign bus.o_B  = r_q;
   assign bus.o_A  = r_start ? w_rdata : '0;
   assign o_busy   = (r_state != ST_IDLE);
   assign o_done   = r_done;
   assign o_err    = r_err;

   // r_rcnt doubles as the run index k; the read for k+1 is issued while k is presented.
   always_comb begin
      w_we    = 1'b0;
      w_addr  = r_rcnt;
      w_wdata = bus.i_base;
      case (r_state)
         ST_LOAD_R: w_we = w_acc;
         ST_PRIME:  w_addr = '0;
         ST_RUN:    w_addr = r_rcnt + ref_addr_t'(1);
         ST_IDLE, ST_LOAD_Q: begin
            if (!ERR_EN && w_acc && bus.i_base_last) begin
               w_we    = 1'b1;
               w_addr  = '0;
               w_wdata = BASE_A;
            end
         end
         default: ;
      endcase
   end

   seq_ref_ram u_ref_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_q     <= '0;
         r_qcnt  <= '0;
         r_rcnt  <= '0;
         r_len   <= '0;
         r_dcnt  <= '0;
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  if (ERR_EN && bus.i_base_last) begin
                     r_err <= 1'b1;
                  end else begin
                     r_q     <= (2*N_PE)'(bus.i_base);
                     r_qcnt  <= 6'd1;
                     r_len   <= ref_addr_t'(1);
                     r_state <= bus.i_base_last ? ST_PRIME : ST_LOAD_Q;
                  end
               end
            end
            ST_LOAD_Q: begin
               if (w_acc) begin
                  if (ERR_EN && bus.i_base_last) begin
                     r_err   <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_q[{r_qcnt, 1'b0} +: 2] <= bus.i_base;
                     r_qcnt <= r_qcnt + 6'd1;
                     if (bus.i_base_last) begin
                        r_state <= ST_PRIME;
                     end else if (r_qcnt == 6'(N_PE-1)) begin
                        r_rcnt  <= '0;
                        r_state <= ST_LOAD_R;
                     end
                  end
               end
            end
            ST_LOAD_R: begin
               if (w_acc) begin
                  if (r_rcnt == ref_addr_t'(MAX_REF)) begin
                     r_len   <= ref_addr_t'(MAX_REF);
                     r_err   <= ERR_EN;
                     r_state <= !bus.i_base_last ? ST_FLUSH :
                                (ERR_EN ? ST_IDLE : ST_PRIME);
                  end else if (bus.i_base_last) begin
                     r_len   <= r_rcnt + ref_addr_t'(1);
                     r_state <= ST_PRIME;
                  end else begin
                     r_rcnt <= r_rcnt + ref_addr_t'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (w_acc && bus.i_base_last) r_state <= ERR_EN ? ST_IDLE : ST_PRIME;
            end
            ST_PRIME: begin
               r_rcnt  <= '0;
               r_start <= 1'b1;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (r_rcnt == r_len - ref_addr_t'(1)) begin
                  r_start <= 1'b0;
                  r_dcnt  <= '0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_rcnt <= r_rcnt + ref_addr_t'(1);
               end
            end
            ST_DRAIN: begin
               r_dcnt <= r_dcnt + 7'd1;
               if (r_dcnt == 7'(DRAIN_CYC-2)) r_done <= 1'b1;
               if (r_dcnt == 7'(DRAIN_CYC-1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_feeder.sv
// Scoreboard bench for seq_feeder: expected o_A/o_B per job queued at drive time, compared during o_start.
module tb_seq_feeder;
   import seq_feeder_pkg::*;

   typedef struct {
      logic [127:0] b;
      int           len;
   } job_t;

   logic clk;
   logic rst;
   logic busy, done, err;

   seq_feeder_if bus();

   seq_feeder dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus    (bus),
      .o_busy (busy),
      .o_done (done),
      .o_err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   job_t jobs[$];
   logic [1:0] exp_a[$];
   logic [1:0] ref_buf[$];
   int   cyc = 0;
   int   starts = 0;
   int   last_start_cyc = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   bit   lock = 0;
   bit   no_run = 0;
   time  t_last_acc = 0;
   time  t_done = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor / scoreboard consumer
   always @(negedge clk) begin
      job_t j;
      cyc++;
      if (!rst) begin
         if (err) begin
            err_cnt++;
            lock = 0;
         end
         if (lock) chk("ready_low_prime_to_drain", 128'(bus.o_base_ready), 128'(0));
         if (bus.i_base_valid && bus.o_base_ready && bus.i_base_last && !no_run) lock = 1;
         if (bus.o_start) begin
            if (exp_a.size() == 0 || jobs.size() == 0) begin
               chk("unexpected_start", 128'(1), 128'(0));
            end else begin
               chk("o_A", 128'(bus.o_A), 128'(exp_a.pop_front()));
               chk("o_B", bus.o_B, jobs[0].b);
            end
            starts++;
            last_start_cyc = cyc;
         end
         if (done) begin
            lock   = 0;
            t_done = $time;
            if (jobs.size() == 0) begin
               chk("unexpected_done", 128'(1), 128'(0));
            end else begin
               j = jobs.pop_front();
               chk("start_len", 128'(starts), 128'(j.len));
               chk("drain_latency", 128'(cyc - last_start_cyc), 128'(65));
            end
            starts = 0;
            done_cnt++;
         end
      end
   end

   task automatic push_base(input logic [1:0] b, input bit lst, input int gap);
      bit acc;
      int w;
      bus.i_base_valid = 1'b0;
      bus.i_base_last  = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.i_base_valid = 1'b1;
      bus.i_base       = b;
      bus.i_base_last  = lst;
      w = 0;
      forever begin
         @(negedge clk);
         acc = bus.o_base_ready;
         if (acc) t_last_acc = $time;
         @(posedge clk);
         #1;
         if (acc) break;
         w++;
         if (w > 4000) begin
            chk("accept_timeout", 128'(0), 128'(1));
            break;
         end
      end
      bus.i_base_valid = 1'b0;
      bus.i_base_last  = 1'b0;
   endtask

   // Sends nq query bases then nr bases of ref_buf; last marks the final base sent.
   task automatic send_raw(input logic [127:0] q, input int nq, input int nr, input int maxgap,
                           output time t_first);
      t_first = 0;
      for (int i = 0; i < nq; i++) begin
         push_base(q[2*i +: 2], (nr == 0) && (i == nq-1), $urandom_range(maxgap, 0));
         if (i == 0) t_first = t_last_acc;
      end
      for (int r = 0; r < nr; r++)
         push_base(ref_buf[r], r == nr-1, $urandom_range(maxgap, 0));
   endtask

   task automatic expect_job(input logic [127:0] b, input int len, input bit zero_ref);
      job_t j;
      j.b = b;
      j.len = len;
      jobs.push_back(j);
      for (int r = 0; r < len; r++) exp_a.push_back(zero_ref ? 2'd0 : ref_buf[r]);
   endtask

   task automatic fill_ref(input int n);
      ref_buf.delete();
      for (int r = 0; r < n; r++) ref_buf.push_back(2'($urandom_range(3, 0)));
   endtask

   function automatic logic [127:0] rand_q();
      logic [127:0] q;
      for (int i = 0; i < 4; i++) q[32*i +: 32] = $urandom;
      return q;
   endfunction

   task automatic wait_done(input int target);
      int w;
      w = 0;
      while (done_cnt < target && w < 10000) begin
         @(negedge clk);
         w++;
      end
      if (done_cnt < target) chk("done_timeout", 128'(done_cnt), 128'(target));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] q, q2;
      time t0;
      int  d, w, e0;

      rst = 1'b1;
      bus.i_base_valid = 1'b0;
      bus.i_base       = 2'd0;
      bus.i_base_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 128'(bus.o_base_ready), 128'(1));
      chk("rst_start", 128'(bus.o_start), 128'(0));
      chk("rst_A", 128'(bus.o_A), 128'(0));
      chk("rst_B", bus.o_B, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      @(posedge clk);
      #1;

      // L=4, query all C, ref G T A C
      d = done_cnt;
      ref_buf.delete();
      ref_buf.push_back(BASE_G); ref_buf.push_back(BASE_T);
      ref_buf.push_back(BASE_A); ref_buf.push_back(BASE_C);
      q = {64{BASE_C}};
      expect_job(q, 4, 1'b0);
      send_raw(q, 64, 4, 0, t0);
      wait_done(d + 1);

      // L=1 turnaround
      d = done_cnt;
      fill_ref(1);
      q = rand_q();
      expect_job(q, 1, 1'b0);
      send_raw(q, 64, 1, 0, t0);
      wait_done(d + 1);
      chk("turnaround_L1", 128'((t_done - t0) / 10 + 1), 128'(132));

      // L=1023 with random valid gaps
      d = done_cnt;
      fill_ref(1023);
      q = rand_q();
      expect_job(q, 1023, 1'b0);
      send_raw(q, 64, 1023, 2, t0);
      wait_done(d + 1);

      // Back-to-back: second job presented while first is still running
      d = done_cnt;
      fill_ref(30);
      q = rand_q();
      expect_job(q, 30, 1'b0);
      send_raw(q, 64, 30, 1, t0);
      fill_ref(10);
      q2 = ~q;
      expect_job(q2, 10, 1'b0);
      send_raw(q2, 64, 10, 0, t0);
      wait_done(d + 2);

`ifdef SEQ_FEEDER_ERR_EN
      e0 = err_cnt;
      no_run = 1;
      q = rand_q();
      send_raw(q, 11, 0, 0, t0);
      repeat (4) @(negedge clk);
      chk("err_early_last", 128'(err_cnt - e0), 128'(1));
      chk("err_early_idle", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      e0 = err_cnt;
      fill_ref(1028);
      send_raw(rand_q(), 64, 1028, 0, t0);
      repeat (4) @(negedge clk);
      chk("err_overlength", 128'(err_cnt - e0), 128'(1));
      chk("err_over_idle", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      no_run = 0;
`else
      d = done_cnt;
      q = rand_q();
      q2 = '0;
      q2[21:0] = q[21:0];
      expect_job(q2, 1, 1'b1);
      send_raw(q, 11, 0, 0, t0);
      wait_done(d + 1);
      d = done_cnt;
      fill_ref(1028);
      q = rand_q();
      expect_job(q, 1023, 1'b0);
      send_raw(q, 64, 1028, 0, t0);
      wait_done(d + 1);
`endif

      // Reset mid-RUN at k=5 of L=20
      fill_ref(20);
      q = rand_q();
      expect_job(q, 20, 1'b0);
      send_raw(q, 64, 20, 0, t0);
      w = 0;
      while (!bus.o_start && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("run_seen_before_reset", 128'(bus.o_start), 128'(1));
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_start", 128'(bus.o_start), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_B", bus.o_B, 128'(0));
      chk("abort_ready", 128'(bus.o_base_ready), 128'(1));
      jobs.delete();
      exp_a.delete();
      starts = 0;
      lock = 0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Job after abort
      d = done_cnt;
      fill_ref(8);
      q = rand_q();
      expect_job(q, 8, 1'b0);
      send_raw(q, 64, 8, 1, t0);
      wait_done(d + 1);

`ifdef SEQ_FEEDER_ERR_EN
      chk("err_pulses_total", 128'(err_cnt), 128'(2));
`else
      chk("err_pulses_total", 128'(err_cnt), 128'(0));
`endif
      chk("leftover_expected_A", 128'(exp_a.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
